// File: rtl/alu4_arbiter.sv
// alu4_arbiter
// Shares one ALU4 datapath between two requesters. The arbiter picks a
// requester round-robin, holds its operands on alu_* for ALU_LAT cycles,
// captures the ALU result and returns it on that requester's response
// channel. Opcodes 110/111 are illegal: they bypass the ALU and answer
// immediately with err=1.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   reqN_valid/ready      request handshake (ready is combinational)
//   reqN_a/b/cin/op       request payload, sampled on the accepting edge
//   respN_valid/ready     response handshake
//   respN_data/cout/v/err response payload, stable while valid is high
//   alu_a/b/cin/op        operands to the shared ALU4 (zero unless executing)
//   alu_out/cout/v        result from the shared ALU4
//   busy                  high whenever the arbiter is not idle
module alu4_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_cin,
  input  logic [2:0] req0_op,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_cin,
  input  logic [2:0] req1_op,

  output logic       resp0_valid,
  input  logic       resp0_ready,
  output logic [7:0] resp0_data,
  output logic       resp0_cout,
  output logic       resp0_v,
  output logic       resp0_err,

  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [7:0] resp1_data,
  output logic       resp1_cout,
  output logic       resp1_v,
  output logic       resp1_err,

  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_cout,
  input  logic       alu_v,

  output logic       busy
);

  localparam int unsigned DW = 4;  // operand width
  localparam int unsigned OW = 3;  // opcode width
  localparam int unsigned RW = 8;  // result width
  localparam int unsigned CW = 4;  // latency counter, covers ALU_LAT up to 15

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic [OW-1:0] op;
  } req_t;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] data;
    logic          cout;
    logic          v;
    logic          err;
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic          last_grant;  // port that won the previous arbitration
  logic          cur;         // port owning the in-flight operation
  logic [CW-1:0] lat_cnt;
  resp_t         resp_q [2];

  logic          grant_c;
  logic          accept_c;
  logic          illegal_c;
  logic          resp_hs_c;
  req_t          sel_req_c;

  // Round-robin grant: a lone requester wins, a tie goes to the port that
  // did not win last time.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  // Ready only in IDLE and only for the granted port, so never both at once.
  assign req0_ready = (state == IDLE) && !reset && req0_valid && !grant_c;
  assign req1_ready = (state == IDLE) && !reset && req1_valid &&  grant_c;
  assign accept_c   = req0_ready || req1_ready;

  // Payload of the granted port.
  always_comb begin
    sel_req_c = '{a: req0_a, b: req0_b, cin: req0_cin, op: req0_op};
    if (grant_c) begin
      sel_req_c = '{a: req1_a, b: req1_b, cin: req1_cin, op: req1_op};
    end
  end

  assign illegal_c = (sel_req_c.op[2:1] == 2'b11);
  assign resp_hs_c = cur ? resp1_ready : resp0_ready;

  // Arbitration / execution FSM with registered datapath outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      lat_cnt    <= '0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_op     <= '0;
      resp_q[0]  <= '0;
      resp_q[1]  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            last_grant <= grant_c;
            cur        <= grant_c;
            busy       <= 1'b1;
            if (illegal_c) begin
              // Illegal opcode: answer at once, leave the ALU untouched.
              state           <= RESP;
              resp_q[grant_c] <= '{valid: 1'b1, data: '0, cout: 1'b0,
                                   v: 1'b0, err: 1'b1};
            end else begin
              state   <= EXEC;
              lat_cnt <= CW'(ALU_LAT - 1);
              alu_a   <= sel_req_c.a;
              alu_b   <= sel_req_c.b;
              alu_cin <= sel_req_c.cin;
              alu_op  <= sel_req_c.op;
            end
          end
        end

        EXEC: begin
          if (lat_cnt == '0) begin
            // Operands have been held ALU_LAT cycles: sample the result.
            state       <= RESP;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            alu_op      <= '0;
            resp_q[cur] <= '{valid: 1'b1, data: alu_out, cout: alu_cout,
                             v: alu_v, err: 1'b0};
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end

        RESP: begin
          if (resp_hs_c) begin
            state       <= IDLE;
            busy        <= 1'b0;
            resp_q[cur] <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign resp0_valid = resp_q[0].valid;
  assign resp0_data  = resp_q[0].data;
  assign resp0_cout  = resp_q[0].cout;
  assign resp0_v     = resp_q[0].v;
  assign resp0_err   = resp_q[0].err;

  assign resp1_valid = resp_q[1].valid;
  assign resp1_data  = resp_q[1].data;
  assign resp1_cout  = resp_q[1].cout;
  assign resp1_v     = resp_q[1].v;
  assign resp1_err   = resp_q[1].err;

endmodule
